flash_op_sequencer: RTL and testbench

- Upstream command sequencer for memory_controller on the CMOD S6 S25FL128S quad-flash path.
- Accepts one high-level host operation and expands it into the required flash command sequence. Example: sector erase becomes WREN (06h) then SE (D8h).
- Drives MEMCMD/MEMADDR/MEMTRIG using the controller's trigger/busy handshake and returns the captured MEMDATA result, a done pulse and an error flag.

---
 rtl/flash_op_sequencer_if.sv | 38 +++
 rtl/flash_op_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_flash_op_sequencer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// flash_op_sequencer_if
//   Command/handshake bus between flash_op_sequencer and memory_controller.
//
//   Signals:
//     MEMCMD         8   command byte to the controller
//     MEMADDR       24   flash address to the controller
//     MEMTRIG        1   trigger; held until the controller raises busy
//     MEM_CTRL_busy  1   controller busy flag (acknowledge and completion)
//     MEMDATA       48   data returned by the controller for the last command
//
//   Modports:
//     master  sequencer side (drives command, samples busy/data)
//     slave   controller side (samples command, drives busy/data)
// ---------------------------------------------------------------------------
interface flash_op_sequencer_if;
  logic [7:0]  MEMCMD;
  logic [23:0] MEMADDR;
  logic        MEMTRIG;
  logic        MEM_CTRL_busy;
  logic [47:0] MEMDATA;

  modport master (
    output MEMCMD,
    output MEMADDR,
    output MEMTRIG,
    input  MEM_CTRL_busy,
    input  MEMDATA
  );

  modport slave (
    input  MEMCMD,
    input  MEMADDR,
    input  MEMTRIG,
    output MEM_CTRL_busy,
    output MEMDATA
  );
endinterface

// File: rtl/flash_op_sequencer.sv
// ---------------------------------------------------------------------------
// flash_op_sequencer
//   Expands one high-level host flash operation into the S25FL128S command
//   sequence expected by memory_controller (e.g. sector erase becomes
//   WREN 06h followed by SE D8h), runs each command through the controller's
//   trigger/busy handshake and reports the final MEMDATA, a done pulse and an
//   error flag.
//
//   Ports:
//     CLK            in   1   system clock
//     reset          in   1   synchronous active-high reset
//     req            in   1   host request, sampled only while ready=1
//     op             in   2   0=RDID 1=READ_SR1 2=SECTOR_ERASE 3=BULK_ERASE
//     addr           in  24   sector address (op=2 only), latched on accept
//     ready          out  1   request can be accepted this cycle
//     done           out  1   one-cycle pulse at the end of every operation
//     err            out  1   error status of the last operation
//     result         out 48   MEMDATA of the last completed sub-command
//     mem            master   command bus to memory_controller
//
//   Parameters:
//     ACK_TIMEOUT    cycles in ISSUE waiting for busy to rise
//     DONE_TIMEOUT   cycles in WAIT_DONE waiting for busy to fall
//
//   Build option:
//     WEL_CHECK_EN   when defined, erase ops read SR1 after WREN and abort
//                    with err=1 if the WEL bit did not get set.
// ---------------------------------------------------------------------------
module flash_op_sequencer #(
  parameter logic [35:0] ACK_TIMEOUT  = 36'd16,
  parameter logic [35:0] DONE_TIMEOUT = 36'h3_0000_0000
) (
  input  logic                 CLK,
  input  logic                 reset,
  input  logic                 req,
  input  logic [1:0]           op,
  input  logic [23:0]          addr,
  output logic                 ready,
  output logic                 done,
  output logic                 err,
  output logic [47:0]          result,
  flash_op_sequencer_if.master mem
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_NEXT      = 3'd4,
    ST_FINISH    = 3'd5
  } state_t;

  localparam logic [7:0] CMD_RDID  = 8'h9F;
  localparam logic [7:0] CMD_RDSR1 = 8'h05;
  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_SE    = 8'hD8;
  localparam logic [7:0] CMD_BE    = 8'hC7;

  // Index of the final sub-command of an erase sequence.
`ifdef WEL_CHECK_EN
  localparam logic [1:0] ERASE_LAST_IDX = 2'd2;
`else
  localparam logic [1:0] ERASE_LAST_IDX = 2'd1;
`endif

  // Command byte for sub-command idx of operation o.
  function automatic logic [7:0] sub_cmd(input logic [1:0] o, input logic [1:0] idx);
    logic [7:0] c;
    c = 8'h00;
    case (o)
      2'd0: c = CMD_RDID;
      2'd1: c = CMD_RDSR1;
      2'd2, 2'd3: begin
        if (idx == 2'd0) begin
          c = CMD_WREN;
`ifdef WEL_CHECK_EN
        end else if (idx == 2'd1) begin
          c = CMD_RDSR1;
`endif
        end else if (o == 2'd2) begin
          c = CMD_SE;
        end else begin
          c = CMD_BE;
        end
      end
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  // Index of the last sub-command for operation o.
  function automatic logic [1:0] last_idx(input logic [1:0] o);
    logic [1:0] l;
    case (o)
      2'd0, 2'd1: l = 2'd0;
      2'd2, 2'd3: l = ERASE_LAST_IDX;
      default:    l = 2'd0;
    endcase
    return l;
  endfunction

  // Saturating increment: timeout counters must never wrap back to zero.
  function automatic logic [35:0] sat_inc(input logic [35:0] v);
    logic [35:0] r;
    if (v == {36{1'b1}}) begin
      r = v;
    end else begin
      r = v + 36'd1;
    end
    return r;
  endfunction

  state_t      state_r, state_d;
  logic [1:0]  op_r, op_d;
  logic [23:0] addr_r, addr_d;
  logic [1:0]  idx_r, idx_d;
  logic [35:0] cnt_r, cnt_d;
  logic [7:0]  memcmd_r, memcmd_d;
  logic [23:0] memaddr_r, memaddr_d;
  logic        memtrig_r, memtrig_d;
  logic        done_r, done_d;
  logic        err_r, err_d;
  logic [47:0] result_r, result_d;

  logic        busy_s;
  logic        accept_s;
  logic        ack_expired_s;
  logic        done_expired_s;
  logic        more_s;
  logic        wel_fail_s;
  logic [7:0]  cur_cmd_s;

  assign busy_s         = mem.MEM_CTRL_busy;
  // ready follows busy combinationally so a request can never be accepted
  // over a controller that is still busy.
  assign ready          = (state_r == ST_IDLE) && !busy_s;
  assign accept_s       = ready && req;
  assign ack_expired_s  = (cnt_r >= (ACK_TIMEOUT - 36'd1));
  assign done_expired_s = (cnt_r >= (DONE_TIMEOUT - 36'd1));
  assign more_s         = (idx_r != last_idx(op_r));
  assign cur_cmd_s      = sub_cmd(op_r, idx_r);

`ifdef WEL_CHECK_EN
  // The SR1 read directly after WREN must show WEL (bit 1) set.
  assign wel_fail_s = op_r[1] && (idx_r == 2'd1) && !result_r[1];
`else
  assign wel_fail_s = 1'b0;
`endif

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      op_r      <= 2'd0;
      addr_r    <= 24'h0;
      idx_r     <= 2'd0;
      cnt_r     <= 36'd0;
      memcmd_r  <= 8'h00;
      memaddr_r <= 24'h0;
      memtrig_r <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      result_r  <= 48'h0;
    end else begin
      state_r   <= state_d;
      op_r      <= op_d;
      addr_r    <= addr_d;
      idx_r     <= idx_d;
      cnt_r     <= cnt_d;
      memcmd_r  <= memcmd_d;
      memaddr_r <= memaddr_d;
      memtrig_r <= memtrig_d;
      done_r    <= done_d;
      err_r     <= err_d;
      result_r  <= result_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_ISSUE;
      ST_ISSUE: begin
        // Acknowledge is checked first so it wins over a same-cycle timeout.
        if (busy_s) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_expired_s) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s) begin
          state_d = ST_NEXT;
        end else if (done_expired_s) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_NEXT: begin
        if (wel_fail_s) begin
          state_d = ST_FINISH;
        end else if (more_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; everything leaves through a register.
  always_comb begin
    op_d      = op_r;
    addr_d    = addr_r;
    idx_d     = idx_r;
    cnt_d     = cnt_r;
    memcmd_d  = memcmd_r;
    memaddr_d = memaddr_r;
    memtrig_d = 1'b0;
    err_d     = err_r;
    result_d  = result_r;
    done_d    = (state_d == ST_FINISH);
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          op_d   = op;
          addr_d = addr;
          idx_d  = 2'd0;
          err_d  = 1'b0;
        end else begin
          op_d   = op_r;
        end
      end
      ST_LOAD: begin
        memcmd_d  = cur_cmd_s;
        // Only the sector erase carries an address.
        if (cur_cmd_s == CMD_SE) begin
          memaddr_d = addr_r;
        end else begin
          memaddr_d = 24'h0;
        end
        memtrig_d = 1'b1;
        cnt_d     = 36'd0;
      end
      ST_ISSUE: begin
        if (busy_s) begin
          memtrig_d = 1'b0;
          cnt_d     = 36'd0;
        end else if (ack_expired_s) begin
          memtrig_d = 1'b0;
          err_d     = 1'b1;
        end else begin
          memtrig_d = 1'b1;
          cnt_d     = sat_inc(cnt_r);
        end
      end
      ST_WAIT_DONE: begin
        if (!busy_s) begin
          result_d = mem.MEMDATA;
        end else if (done_expired_s) begin
          err_d    = 1'b1;
        end else begin
          cnt_d    = sat_inc(cnt_r);
        end
      end
      ST_NEXT: begin
        if (wel_fail_s) begin
          err_d = 1'b1;
        end else if (more_s) begin
          idx_d = idx_r + 2'd1;
        end else begin
          idx_d = idx_r;
        end
      end
      ST_FINISH: begin
        idx_d = idx_r;
      end
      default: begin
        idx_d = idx_r;
      end
    endcase
  end

  assign done        = done_r;
  assign err         = err_r;
  assign result      = result_r;
  assign mem.MEMCMD  = memcmd_r;
  assign mem.MEMADDR = memaddr_r;
  assign mem.MEMTRIG = memtrig_r;

endmodule

// File: tb/tb_flash_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_flash_op_sequencer
//   Directed bench for flash_op_sequencer with a small memory_controller
//   model (configurable acknowledge delay and busy length) that logs every
//   command it is triggered with.
// ---------------------------------------------------------------------------
module tb_flash_op_sequencer;

  localparam logic [47:0] RDID_DATA = 48'h0120_1845_0000;

  logic        CLK;
  logic        reset;
  logic        req;
  logic [1:0]  op;
  logic [23:0] addr;
  logic        ready;
  logic        done;
  logic        err;
  logic [47:0] result;

  flash_op_sequencer_if mem_if();

  flash_op_sequencer dut (
    .CLK    (CLK),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .ready  (ready),
    .done   (done),
    .err    (err),
    .result (result),
    .mem    (mem_if)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Model configuration, written only by the stimulus thread.
  int         m_ack_delay = 0;
  int         m_busy_len  = 1;
  logic       m_never_ack = 1'b0;
  logic       force_busy  = 1'b0;
  logic [7:0] m_status    = 8'h02;

  // Model state and logs, written only by the model.
  int          m_phase = 0;
  int          m_cnt   = 0;
  logic        m_busy  = 1'b0;
  logic        prev_trig = 1'b0;
  logic [7:0]  m_cur_cmd = 8'h00;
  int          trig_count = 0;
  int          trig_high_cycles = 0;
  int          done_count = 0;
  logic [7:0]  cmd_log  [64];
  logic [23:0] addr_log [64];

  // memory_controller model, updated on the falling edge.
  always @(negedge CLK) begin
    if (reset) begin
      m_phase   = 0;
      m_cnt     = 0;
      m_busy    = 1'b0;
      prev_trig = 1'b0;
      mem_if.MEMDATA = 48'h0;
    end else begin
      if (mem_if.MEMTRIG) trig_high_cycles++;
      if (mem_if.MEMTRIG && !prev_trig) begin
        cmd_log[trig_count[5:0]]  = mem_if.MEMCMD;
        addr_log[trig_count[5:0]] = mem_if.MEMADDR;
        trig_count++;
      end
      case (m_phase)
        0: begin
          if (mem_if.MEMTRIG && !prev_trig && !m_never_ack) begin
            m_cur_cmd = mem_if.MEMCMD;
            if (m_ack_delay == 0) begin
              m_busy = 1'b1; m_cnt = m_busy_len; m_phase = 2;
            end else begin
              m_cnt = m_ack_delay; m_phase = 1;
            end
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 1'b1; m_cnt = m_busy_len; m_phase = 2;
          end
        end
        2: begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_busy = 1'b0;
            m_phase = 0;
            if (m_cur_cmd == 8'h9F) mem_if.MEMDATA = RDID_DATA;
            else if (m_cur_cmd == 8'h05) mem_if.MEMDATA = {40'h0, m_status};
            else mem_if.MEMDATA = 48'h0;
          end
        end
        default: m_phase = 0;
      endcase
      prev_trig = mem_if.MEMTRIG;
    end
    mem_if.MEM_CTRL_busy = m_busy | force_busy;
  end

  // Count done pulses.
  always @(negedge CLK) begin
    if (done === 1'b1) done_count++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  // Issue one request and wait (bounded) for done; cycles counts steps from
  // the request cycle up to the cycle in which done is visible.
  task automatic run_op(input logic [1:0] o, input logic [23:0] a,
                        output int cycles, output logic got_done);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin step(); n++; end
    if (ready !== 1'b1) check_eq("ready_wait", 64'(ready), 64'd1);
    op = o; addr = a; req = 1'b1;
    step();
    cycles = 1;
    req = 1'b0;
    while (done !== 1'b1 && cycles < 2000) begin step(); cycles++; end
    got_done = (done === 1'b1);
  endtask

  int   cyc;
  logic gd;
  int   tb0, hb0, db0;

  initial begin
    reset = 1'b1; req = 1'b0; op = 2'd0; addr = 24'h0;
    repeat (3) step();
    check_eq("rst_ready",   64'(ready), 64'd1);
    check_eq("rst_done",    64'(done), 64'd0);
    check_eq("rst_err",     64'(err), 64'd0);
    check_eq("rst_result",  64'(result), 64'd0);
    check_eq("rst_memcmd",  64'(mem_if.MEMCMD), 64'd0);
    check_eq("rst_memaddr", 64'(mem_if.MEMADDR), 64'd0);
    check_eq("rst_memtrig", 64'(mem_if.MEMTRIG), 64'd0);
    reset = 1'b0;
    step();

    // RDID: ack after 2 cycles, busy for 10.
    m_ack_delay = 2; m_busy_len = 10;
    tb0 = trig_count; db0 = done_count;
    run_op(2'd0, 24'h0, cyc, gd);
    check_eq("rdid_done",   64'(gd), 64'd1);
    check_eq("rdid_err",    64'(err), 64'd0);
    check_eq("rdid_result", 64'(result), 64'(RDID_DATA));
    check_eq("rdid_ntrig",  64'(trig_count - tb0), 64'd1);
    check_eq("rdid_cmd",    64'(cmd_log[tb0[5:0]]), 64'h9F);
    check_eq("rdid_addr",   64'(addr_log[tb0[5:0]]), 64'h0);
    step(); step();
    check_eq("rdid_one_done", 64'(done_count - db0), 64'd1);
    check_eq("rdid_ready",    64'(ready), 64'd1);

    // READ_SR1 latency: accept, LOAD, ISSUE, 3x WAIT_DONE, NEXT, FINISH -> 7.
    m_ack_delay = 0; m_busy_len = 3; m_status = 8'h02;
    tb0 = trig_count;
    run_op(2'd1, 24'h0, cyc, gd);
    check_eq("sr1_done",    64'(gd), 64'd1);
    check_eq("sr1_latency", 64'(cyc), 64'd7);
    check_eq("sr1_result",  64'(result), 64'h02);
    check_eq("sr1_cmd",     64'(cmd_log[tb0[5:0]]), 64'h05);

    // Sector erase at 0x050000.
    m_ack_delay = 1; m_busy_len = 4;
    tb0 = trig_count; db0 = done_count;
    run_op(2'd2, 24'h05_0000, cyc, gd);
    check_eq("se_done", 64'(gd), 64'd1);
    check_eq("se_err",  64'(err), 64'd0);
    check_eq("se_cmd0", 64'(cmd_log[tb0[5:0]]), 64'h06);
    check_eq("se_addr0", 64'(addr_log[tb0[5:0]]), 64'h0);
`ifdef WEL_CHECK_EN
    check_eq("se_ntrig", 64'(trig_count - tb0), 64'd3);
    check_eq("se_cmd1",  64'(cmd_log[(tb0 + 1) & 63]), 64'h05);
    check_eq("se_cmd2",  64'(cmd_log[(tb0 + 2) & 63]), 64'hD8);
    check_eq("se_addr2", 64'(addr_log[(tb0 + 2) & 63]), 64'h05_0000);
`else
    check_eq("se_ntrig", 64'(trig_count - tb0), 64'd2);
    check_eq("se_cmd1",  64'(cmd_log[(tb0 + 1) & 63]), 64'hD8);
    check_eq("se_addr1", 64'(addr_log[(tb0 + 1) & 63]), 64'h05_0000);
`endif
    step(); step();
    check_eq("se_one_done", 64'(done_count - db0), 64'd1);

    // Ack lands on the last allowed ISSUE cycle: acknowledge wins.
    m_ack_delay = 15; m_busy_len = 2;
    hb0 = trig_high_cycles;
    run_op(2'd0, 24'h0, cyc, gd);
    check_eq("late_ack_done",   64'(gd), 64'd1);
    check_eq("late_ack_err",    64'(err), 64'd0);
    check_eq("late_ack_trig",   64'(trig_high_cycles - hb0), 64'd16);
    check_eq("late_ack_result", 64'(result), 64'(RDID_DATA));

    // No acknowledge at all: 16 ISSUE cycles then error.
    m_never_ack = 1'b1;
    hb0 = trig_high_cycles;
    run_op(2'd0, 24'h0, cyc, gd);
    check_eq("to_done",     64'(gd), 64'd1);
    check_eq("to_err",      64'(err), 64'd1);
    check_eq("to_trig",     64'(trig_high_cycles - hb0), 64'd16);
    check_eq("to_trig_low", 64'(mem_if.MEMTRIG), 64'd0);
    check_eq("to_ready_fin", 64'(ready), 64'd0);
    step();
    check_eq("to_ready", 64'(ready), 64'd1);
    m_never_ack = 1'b0;
    step(); step();
    check_eq("to_err_held", 64'(err), 64'd1);

    // Busy already high: request blocked and dropped.
    force_busy = 1'b1;
    step(); step();
    tb0 = trig_count; db0 = done_count;
    req = 1'b1; op = 2'd0;
    step();
    check_eq("blk_ready", 64'(ready), 64'd0);
    step(); step();
    req = 1'b0;
    force_busy = 1'b0;
    step(); step();
    check_eq("blk_ready_back", 64'(ready), 64'd1);
    repeat (10) step();
    check_eq("blk_no_trig", 64'(trig_count - tb0), 64'd0);
    check_eq("blk_no_done", 64'(done_count - db0), 64'd0);

`ifdef WEL_CHECK_EN
    // WEL not set after WREN: erase skipped.
    m_ack_delay = 0; m_busy_len = 2; m_status = 8'h00;
    tb0 = trig_count;
    run_op(2'd2, 24'h12_0000, cyc, gd);
    check_eq("wel_done",  64'(gd), 64'd1);
    check_eq("wel_err",   64'(err), 64'd1);
    check_eq("wel_ntrig", 64'(trig_count - tb0), 64'd2);
    check_eq("wel_cmd0",  64'(cmd_log[tb0[5:0]]), 64'h06);
    check_eq("wel_cmd1",  64'(cmd_log[(tb0 + 1) & 63]), 64'h05);
    m_status = 8'h02;
`else
    // Bulk erase runs to completion.
    m_ack_delay = 0; m_busy_len = 2;
    tb0 = trig_count;
    run_op(2'd3, 24'h12_3456, cyc, gd);
    check_eq("be_done",  64'(gd), 64'd1);
    check_eq("be_err",   64'(err), 64'd0);
    check_eq("be_ntrig", 64'(trig_count - tb0), 64'd2);
    check_eq("be_cmd1",  64'(cmd_log[(tb0 + 1) & 63]), 64'hC7);
    check_eq("be_addr1", 64'(addr_log[(tb0 + 1) & 63]), 64'h0);
`endif

    // Reset in WAIT_DONE of a bulk erase abandons the sequence.
    m_ack_delay = 0; m_busy_len = 20;
    repeat (3) step();
    tb0 = trig_count; db0 = done_count;
    op = 2'd3; addr = 24'h0; req = 1'b1;
    step();
    req = 1'b0;
    cyc = 0;
    while (!(mem_if.MEM_CTRL_busy === 1'b1 && trig_count - tb0 == 1) && cyc < 100) begin
      step(); cyc++;
    end
    check_eq("rmid_in_wait", 64'(mem_if.MEM_CTRL_busy), 64'd1);
    step();
    reset = 1'b1;
    step();
    check_eq("rmid_memtrig", 64'(mem_if.MEMTRIG), 64'd0);
    check_eq("rmid_ready",   64'(ready), 64'd1);
    check_eq("rmid_done",    64'(done), 64'd0);
    check_eq("rmid_result",  64'(result), 64'd0);
    reset = 1'b0;
    repeat (30) step();
    check_eq("rmid_one_cmd", 64'(trig_count - tb0), 64'd1);
    check_eq("rmid_no_done", 64'(done_count - db0), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
